// File: rtl/write_buffer.sv
// write_buffer: write-through store FIFO between the data cache and main
// memory. Drains one entry per cycle when the memory port is free, forwards
// the newest buffered data to read misses, and supports a flush handshake.
module write_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_req,
   input  logic [AW-1:0]            wr_addr,
   input  logic [DW-1:0]            wr_data,
   output logic                     wr_ready,
   input  logic                     rd_req,
   input  logic [AW-1:0]            rd_addr,
   output logic                     fwd_hit,
   output logic [DW-1:0]            fwd_data,
   output logic                     mem_we,
   output logic [AW-1:0]            mem_addr,
   output logic [DW-1:0]            mem_wdata,
   input  logic                     flush,
   output logic                     flush_done,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_FLUSH
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             flush_done_q, flush_done_d;
   logic [AW-1:0]    addr_q [DEPTH];
   logic [AW-1:0]    addr_d [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DW-1:0]    data_d [DEPTH];

   logic             enq;
   logic             deq;

   // Port handshakes: a full buffer or an active flush blocks stores; read misses own the port.
   always_comb begin
      wr_ready = (count_q != CW'(DEPTH)) && (state_q != S_FLUSH);
      mem_we   = (count_q != CW'(0)) && !rd_req && (state_q != S_IDLE);
      enq      = wr_req && wr_ready;
      deq      = mem_we;
   end

   // Memory port and status outputs driven from the head entry and counters.
   always_comb begin
      mem_addr   = rd_req ? rd_addr : addr_q[head_q];
      mem_wdata  = data_q[head_q];
      empty      = (count_q == CW'(0));
      count      = count_q;
      flush_done = flush_done_q;
   end

   // Forwarding: scan valid entries oldest to newest so the newest match wins.
   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head_q + PW'(k);
         if ((CW'(k) < count_q) && (addr_q[idx] == rd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[idx];
         end
      end
   end

   // Next-state: pointer/count update, entry write, and FSM transitions.
   always_comb begin
      state_d      = state_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      flush_done_d = 1'b0;
      addr_d       = addr_q;
      data_d       = data_q;

      if (enq) begin
         addr_d[tail_q] = wr_addr;
         data_d[tail_q] = wr_data;
         tail_d         = tail_q + PW'(1);
      end
      if (deq) begin
         head_d = head_q + PW'(1);
      end
      if (enq && !deq) begin
         count_d = count_q + CW'(1);
      end else if (!enq && deq) begin
         count_d = count_q - CW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (flush) begin
               state_d = S_FLUSH;
            end else if (enq) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (flush) begin
               state_d = S_FLUSH;
            end else if (count_d == CW'(0)) begin
               state_d = S_IDLE;
            end
         end
         S_FLUSH: begin
            if (count_q == CW'(0)) begin
               state_d      = S_IDLE;
               flush_done_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control registers with synchronous reset; reset discards pending stores.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         flush_done_q <= flush_done_d;
      end
   end

   // Entry storage needs no reset: only entries below count are ever observed.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: directed vector table plus hand-written flush/reset sequences.
module tb_write_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_req;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        rd_req;
   logic [7:0]  rd_addr;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        flush;
   logic        flush_done;
   logic        empty;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   write_buffer #(.DEPTH(4), .AW(8), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_req(rd_req), .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .flush(flush), .flush_done(flush_done), .empty(empty), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [7:0]  wa;
      logic [31:0] wd;
      logic        rd;
      logic [7:0]  ra;
      logic        e_rdy;
      logic        e_we;
      logic        c_ma;
      logic [7:0]  e_ma;
      logic        c_md;
      logic [31:0] e_md;
      logic        e_hit;
      logic [31:0] e_fd;
      logic        e_empty;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vecs [21];

   function automatic vec_t mk(input logic wr, input logic [7:0] wa, input logic [31:0] wd,
                               input logic rd, input logic [7:0] ra,
                               input logic e_rdy, input logic e_we,
                               input logic c_ma, input logic [7:0] e_ma,
                               input logic c_md, input logic [31:0] e_md,
                               input logic e_hit, input logic [31:0] e_fd,
                               input logic e_empty, input logic [2:0] e_cnt);
      vec_t v;
      v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra;
      v.e_rdy = e_rdy; v.e_we = e_we; v.c_ma = c_ma; v.e_ma = e_ma;
      v.c_md = c_md; v.e_md = e_md; v.e_hit = e_hit; v.e_fd = e_fd;
      v.e_empty = e_empty; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Set all inputs for the coming cycle.
   task automatic drive(input logic r, input logic wr, input logic [7:0] wa, input logic [31:0] wd,
                        input logic rd, input logic [7:0] ra, input logic fl);
      rst = r; wr_req = wr; wr_addr = wa; wr_data = wd;
      rd_req = rd; rd_addr = ra; flush = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   int we_cnt;
   int fd_cnt;

   initial begin
      // Directed table: one row per cycle, outputs checked mid-cycle.
      vecs[0]  = mk(1, 8'h10, 32'hA,   0, 8'hFF, 1, 0, 0, 8'h00, 0, 32'h0,   0, 32'h0, 1, 3'd0);
      vecs[1]  = mk(1, 8'h11, 32'hB,   0, 8'hFF, 1, 1, 1, 8'h10, 1, 32'hA,   0, 32'h0, 0, 3'd1);
      vecs[2]  = mk(0, 8'h00, 32'h0,   0, 8'hFF, 1, 1, 1, 8'h11, 1, 32'hB,   0, 32'h0, 0, 3'd1);
      vecs[3]  = mk(0, 8'h00, 32'h0,   0, 8'hFF, 1, 0, 0, 8'h00, 0, 32'h0,   0, 32'h0, 1, 3'd0);
      vecs[4]  = mk(1, 8'h30, 32'h100, 1, 8'h40, 1, 0, 1, 8'h40, 0, 32'h0,   0, 32'h0, 1, 3'd0);
      vecs[5]  = mk(1, 8'h31, 32'h101, 1, 8'h40, 1, 0, 1, 8'h40, 0, 32'h0,   0, 32'h0, 0, 3'd1);
      vecs[6]  = mk(1, 8'h32, 32'h102, 1, 8'h40, 1, 0, 1, 8'h40, 0, 32'h0,   0, 32'h0, 0, 3'd2);
      vecs[7]  = mk(1, 8'h33, 32'h103, 1, 8'h40, 1, 0, 1, 8'h40, 0, 32'h0,   0, 32'h0, 0, 3'd3);
      vecs[8]  = mk(1, 8'h34, 32'h104, 1, 8'h40, 0, 0, 1, 8'h40, 0, 32'h0,   0, 32'h0, 0, 3'd4);
      vecs[9]  = mk(1, 8'h35, 32'h105, 0, 8'hFF, 0, 1, 1, 8'h30, 1, 32'h100, 0, 32'h0, 0, 3'd4);
      vecs[10] = mk(0, 8'h00, 32'h0,   0, 8'hFF, 1, 1, 1, 8'h31, 1, 32'h101, 0, 32'h0, 0, 3'd3);
      vecs[11] = mk(0, 8'h00, 32'h0,   0, 8'hFF, 1, 1, 1, 8'h32, 1, 32'h102, 0, 32'h0, 0, 3'd2);
      vecs[12] = mk(0, 8'h00, 32'h0,   0, 8'hFF, 1, 1, 1, 8'h33, 1, 32'h103, 0, 32'h0, 0, 3'd1);
      vecs[13] = mk(0, 8'h00, 32'h0,   0, 8'hFF, 1, 0, 0, 8'h00, 0, 32'h0,   0, 32'h0, 1, 3'd0);
      vecs[14] = mk(1, 8'h20, 32'h1,   1, 8'h40, 1, 0, 1, 8'h40, 0, 32'h0,   0, 32'h0, 1, 3'd0);
      vecs[15] = mk(1, 8'h20, 32'h2,   1, 8'h40, 1, 0, 1, 8'h40, 0, 32'h0,   0, 32'h0, 0, 3'd1);
      vecs[16] = mk(0, 8'h00, 32'h0,   1, 8'h20, 1, 0, 1, 8'h20, 0, 32'h0,   1, 32'h2, 0, 3'd2);
      vecs[17] = mk(0, 8'h00, 32'h0,   1, 8'h21, 1, 0, 1, 8'h21, 0, 32'h0,   0, 32'h0, 0, 3'd2);
      vecs[18] = mk(0, 8'h00, 32'h0,   0, 8'h20, 1, 1, 1, 8'h20, 1, 32'h1,   1, 32'h2, 0, 3'd2);
      vecs[19] = mk(0, 8'h00, 32'h0,   0, 8'hFF, 1, 1, 1, 8'h20, 1, 32'h2,   0, 32'h0, 0, 3'd1);
      vecs[20] = mk(0, 8'h00, 32'h0,   0, 8'hFF, 1, 0, 0, 8'h00, 0, 32'h0,   0, 32'h0, 1, 3'd0);

      drive(1, 0, 8'h00, 32'h0, 0, 8'hFF, 0);
      step();
      step();
      drive(0, 0, 8'h00, 32'h0, 0, 8'hFF, 0);
      sample();
      chk("rst_rdy",   32'(wr_ready),   32'h1);
      chk("rst_we",    32'(mem_we),     32'h0);
      chk("rst_hit",   32'(fwd_hit),    32'h0);
      chk("rst_fd",    fwd_data,        32'h0);
      chk("rst_fdone", 32'(flush_done), 32'h0);
      chk("rst_empty", 32'(empty),      32'h1);
      chk("rst_cnt",   32'(count),      32'h0);
      step();

      for (int i = 0; i < 21; i++) begin
         drive(0, vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].rd, vecs[i].ra, 0);
         sample();
         chk($sformatf("r%0d_rdy", i),   32'(wr_ready), 32'(vecs[i].e_rdy));
         chk($sformatf("r%0d_we", i),    32'(mem_we),   32'(vecs[i].e_we));
         if (vecs[i].c_ma) chk($sformatf("r%0d_maddr", i), 32'(mem_addr), 32'(vecs[i].e_ma));
         if (vecs[i].c_md) chk($sformatf("r%0d_mdata", i), mem_wdata, vecs[i].e_md);
         chk($sformatf("r%0d_hit", i),   32'(fwd_hit),  32'(vecs[i].e_hit));
         chk($sformatf("r%0d_fd", i),    fwd_data,      vecs[i].e_fd);
         chk($sformatf("r%0d_fdone", i), 32'(flush_done), 32'h0);
         chk($sformatf("r%0d_empty", i), 32'(empty),    32'(vecs[i].e_empty));
         chk($sformatf("r%0d_cnt", i),   32'(count),    32'(vecs[i].e_cnt));
         step();
      end

      // Flush with three pending stores.
      drive(0, 1, 8'h50, 32'h5, 1, 8'h40, 0); step();
      drive(0, 1, 8'h51, 32'h6, 1, 8'h40, 0); step();
      drive(0, 1, 8'h52, 32'h7, 1, 8'h40, 0); step();
      drive(0, 0, 8'h00, 32'h0, 0, 8'hFF, 1);
      sample();
      chk("fl0_rdy",  32'(wr_ready), 32'h1);
      chk("fl0_we",   32'(mem_we),   32'h1);
      chk("fl0_ma",   32'(mem_addr), 32'h50);
      chk("fl0_cnt",  32'(count),    32'h3);
      step();
      drive(0, 1, 8'h99, 32'h99, 0, 8'hFF, 0);
      sample();
      chk("fl1_rdy",   32'(wr_ready),   32'h0);
      chk("fl1_we",    32'(mem_we),     32'h1);
      chk("fl1_ma",    32'(mem_addr),   32'h51);
      chk("fl1_cnt",   32'(count),      32'h2);
      chk("fl1_fdone", 32'(flush_done), 32'h0);
      step();
      drive(0, 0, 8'h00, 32'h0, 0, 8'hFF, 0);
      sample();
      chk("fl2_rdy",   32'(wr_ready),   32'h0);
      chk("fl2_we",    32'(mem_we),     32'h1);
      chk("fl2_ma",    32'(mem_addr),   32'h52);
      chk("fl2_md",    mem_wdata,       32'h7);
      chk("fl2_fdone", 32'(flush_done), 32'h0);
      step();
      sample();
      chk("fl3_rdy",   32'(wr_ready),   32'h0);
      chk("fl3_we",    32'(mem_we),     32'h0);
      chk("fl3_empty", 32'(empty),      32'h1);
      chk("fl3_fdone", 32'(flush_done), 32'h0);
      step();
      sample();
      chk("fl4_rdy",   32'(wr_ready),   32'h1);
      chk("fl4_fdone", 32'(flush_done), 32'h1);
      chk("fl4_we",    32'(mem_we),     32'h0);
      step();
      sample();
      chk("fl5_fdone", 32'(flush_done), 32'h0);
      chk("fl5_cnt",   32'(count),      32'h0);
      step();

      // Flush of an empty buffer; a repeated flush while flushing is ignored.
      we_cnt = 0;
      fd_cnt = 0;
      drive(0, 0, 8'h00, 32'h0, 0, 8'hFF, 1);
      sample();
      chk("ef0_fdone", 32'(flush_done), 32'h0);
      step();
      sample();
      chk("ef1_rdy",   32'(wr_ready),   32'h0);
      chk("ef1_fdone", 32'(flush_done), 32'h0);
      step();
      drive(0, 0, 8'h00, 32'h0, 0, 8'hFF, 0);
      sample();
      chk("ef2_fdone", 32'(flush_done), 32'h1);
      chk("ef2_rdy",   32'(wr_ready),   32'h1);
      for (int c = 0; c < 4; c++) begin
         step();
         sample();
         if (mem_we) we_cnt++;
         if (flush_done) fd_cnt++;
      end
      chk("ef_we_total",    32'(we_cnt), 32'h0);
      chk("ef_extra_fdone", 32'(fd_cnt), 32'h0);
      step();

      // Reset while three stores are pending and draining.
      drive(0, 1, 8'h60, 32'h60, 1, 8'h40, 0); step();
      drive(0, 1, 8'h61, 32'h61, 1, 8'h40, 0); step();
      drive(0, 1, 8'h62, 32'h62, 1, 8'h40, 0); step();
      drive(1, 0, 8'h00, 32'h0, 0, 8'hFF, 0);
      sample();
      chk("rs0_cnt", 32'(count),  32'h3);
      chk("rs0_we",  32'(mem_we), 32'h1);
      step();
      drive(0, 0, 8'h00, 32'h0, 0, 8'hFF, 0);
      sample();
      chk("rs1_cnt",   32'(count),    32'h0);
      chk("rs1_empty", 32'(empty),    32'h1);
      chk("rs1_we",    32'(mem_we),   32'h0);
      chk("rs1_rdy",   32'(wr_ready), 32'h1);
      we_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         sample();
         if (mem_we) we_cnt++;
      end
      chk("rs_we_after", 32'(we_cnt), 32'h0);
      step();
      drive(0, 1, 8'h70, 32'h77, 0, 8'hFF, 0);
      step();
      drive(0, 0, 8'h00, 32'h0, 0, 8'hFF, 0);
      sample();
      chk("rs2_we",  32'(mem_we),   32'h1);
      chk("rs2_ma",  32'(mem_addr), 32'h70);
      chk("rs2_md",  mem_wdata,     32'h77);
      step();
      sample();
      chk("rs3_empty", 32'(empty), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
